// File: rtl/fa4_rom_responder.sv
// fa4_rom_responder: program-memory responder on the FA4 4-bit multiplexed
// instruction bus. A fetch collects a 12-bit address as three nibbles after
// sync. It then returns the addressed byte as two nibbles, high nibble first.
// The memory is written through a byte-wide programming port, and only while
// the bus is idle.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   sync               CPU cycle marker; the first address nibble follows it
//   addr_in[3:0]       address nibble (low, mid, high)
//   data_out[3:0]      instruction nibble, 0 when data_oe=0
//   data_oe            data_out valid (M1, M2)
//   fetch_addr         last fully assembled fetch address
//   fetch_done         one-cycle pulse while the low nibble is driven
//   prog_we/addr/data  program-memory write port
//   prog_ready         write accepted this cycle (state IDLE)
//   prog_err           sticky: write attempted while busy
module fa4_rom_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 12,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sync,
  input  logic [3:0]        addr_in,
  output logic [3:0]        data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic              prog_ready,
  output logic              prog_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_A1   = 4'd1;
  localparam logic [3:0] S_A2   = 4'd2;
  localparam logic [3:0] S_A3   = 4'd3;
  localparam logic [3:0] S_M1   = 4'd4;
  localparam logic [3:0] S_M2   = 4'd5;
  localparam logic [3:0] S_X1   = 4'd6;
  localparam logic [3:0] S_X2   = 4'd7;
  localparam logic [3:0] S_X3   = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [3:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              fetch_done_q, fetch_done_d;
  logic              prog_ready_q, prog_ready_d;
  logic              prog_err_q, prog_err_d;
  logic              wr_en_c;

  logic [7:0]        mem [DEPTH];

  // High nibble comes straight off the bus during A3, so the full address
  // is available for the read issued on the A3->M1 edge.
  logic [ADDR_W-1:0] full_addr_c;
  logic [7:0]        rd_byte_c;
  assign full_addr_c = ADDR_W'({addr_in, addr_q});
  assign rd_byte_c   = (32'(full_addr_c) < DEPTH) ? mem[full_addr_c[IDX_W-1:0]] : FILL;

  // Next state, address assembly, programming control and registered outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_d       = byte_q;
    fetch_addr_d = fetch_addr_q;
    prog_err_d   = prog_err_q;
    wr_en_c      = 1'b0;
    data_out_d   = 4'h0;
    data_oe_d    = 1'b0;
    fetch_done_d = 1'b0;

    case (state_q)
      S_A1:    addr_d[3:0] = addr_in;
      S_A2:    addr_d[7:4] = addr_in;
      default: ;
    endcase

    if (sync) begin
      state_d = S_A1;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_A1:    state_d = S_A2;
        S_A2:    state_d = S_A3;
        S_A3: begin
          state_d      = S_M1;
          fetch_addr_d = full_addr_c;
          byte_d       = rd_byte_c;
        end
        S_M1:    state_d = S_M2;
        S_M2:    state_d = S_X1;
        S_X1:    state_d = S_X2;
        S_X2:    state_d = S_X3;
        S_X3:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs follow the state being entered so they are valid in that state
    if (state_d == S_M1) begin
      data_out_d = rd_byte_c[7:4];
      data_oe_d  = 1'b1;
    end else if (state_d == S_M2) begin
      data_out_d   = byte_q[3:0];
      data_oe_d    = 1'b1;
      fetch_done_d = 1'b1;
    end

    prog_ready_d = (state_d == S_IDLE);

    if (prog_we) begin
      if (state_q == S_IDLE) begin
        wr_en_c = (32'(prog_addr) < DEPTH);
      end else begin
        prog_err_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 8'h00;
      byte_q       <= 8'h00;
      fetch_addr_q <= '0;
      data_out_q   <= 4'h0;
      data_oe_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      prog_ready_q <= 1'b1;
      prog_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_q       <= byte_d;
      fetch_addr_q <= fetch_addr_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      fetch_done_q <= fetch_done_d;
      prog_ready_q <= prog_ready_d;
      prog_err_q   <= prog_err_d;
    end
  end

  // Program memory; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && wr_en_c) begin
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

  assign data_out   = data_out_q;
  assign data_oe    = data_oe_q;
  assign fetch_addr = fetch_addr_q;
  assign fetch_done = fetch_done_q;
  assign prog_ready = prog_ready_q;
  assign prog_err   = prog_err_q;

endmodule
